mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants after which a waiting fetch is granted first.
REQ-002 SHALL have ports clk in 1, system clock; rst in 1, reset, synchronous, active-high.
REQ-003 SHALL have port flush in 1, branch misprediction flush.
REQ-004 SHALL have ports if_req in 1, instruction fetch request; if_addr in 32, fetch address; if_done out 1, fetch complete pulse; if_rdata out 32, fetched word.
REQ-005 SHALL have ports mem_req in 1, data request; mem_wr in 1, 1 = store; mem_addr in 32, data address; mem_wdata in 32, store data; mem_len in 2, 01/10/11 = 1/2/4 bytes; mem_done out 1, data complete pulse; mem_rdata out 32, load data.
REQ-006 SHALL have downstream ports ctl_valid out 1; ctl_wr out 1; ctl_addr out 32; ctl_wdata out 32; ctl_len out 2 (fetch = 11); ctl_ready in 1; ctl_done in 1; ctl_rdata in 32.
REQ-007 SHALL have port busy out 1, high in every state except IDLE.

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT, DROP.
REQ-009 IDLE: with any request sampled, SHALL latch the winner's address, data, length and source, then enter ISSUE on the next cycle.
REQ-010 Default arbitration SHALL give data priority over fetch.
REQ-011 ISSUE SHALL hold ctl_valid high with stable ctl_* fields until the cycle ctl_ready is high, then enter WAIT.
REQ-012 WAIT on ctl_done SHALL register ctl_rdata into the owner's rdata output, pulse the owner's done for exactly one cycle, and return to IDLE.
REQ-013 Latency SHALL be: req to ctl_valid = 2 cycles; ctl_done to done pulse = 1 cycle.
REQ-014 Requesters SHALL hold req and their fields until done; the arbiter SHALL NOT re-grant a source whose done is pulsing in the same cycle.
REQ-015 Flush with fetch selected or in ISSUE SHALL drop ctl_valid and return to IDLE; no done pulse.
REQ-016 Flush with fetch in WAIT SHALL enter DROP, wait for ctl_done, discard the data, suppress if_done, then enter IDLE.
REQ-017 Flush in IDLE SHALL mask if_req for that cycle; a simultaneous mem_req SHALL still be granted.
REQ-018 Flush SHALL never cancel or delay a data transaction.
REQ-019 if_rdata and mem_rdata SHALL hold their last value between done pulses.
REQ-020 A store with mem_len = 00 SHALL complete immediately: mem_done one cycle after the grant, no downstream access.

Reset
REQ-021 Reset SHALL force IDLE; all outputs 0; the starvation counter 0; latched fields 0.
REQ-022 Reset mid-transaction SHALL abandon it with no done pulse; a later ctl_done in IDLE SHALL be ignored.

Configuration
REQ-023 Macro MEM_ARB_STARVE_GUARD_EN defined: SHALL count consecutive data grants while if_req is high, saturating at STARVE_LIMIT; at the limit the next arbitration SHALL grant fetch; any fetch grant SHALL clear the counter.
REQ-024 Macro undefined: SHALL use strict data priority; no counter logic and STARVE_LIMIT unused.

Structure
REQ-025 State encoding, length codes (LEN_B/H/W) and source codes (SRC_IF/SRC_MEM) SHALL reside in the shared defines package.
REQ-026 One sub-module, mem_arb_pick (combinational winner select plus starvation counter), SHALL be used; the FSM stays in mem_arbiter.

Verification
REQ-027 if_req only, addr 0x1000, ctl_ready immediate, ctl_done with rdata 0x00C0FFEE after 5 cycles -> ctl_len = 11, if_done one cycle later, if_rdata = 0x00C0FFEE.
REQ-028 if_req and mem_req (load 0x2000, len 10) in the same cycle -> data served first, then fetch; exactly one done pulse each.
REQ-029 Flush while fetch is in WAIT -> DROP; ctl_done is absorbed, if_done stays 0, busy falls one cycle after ctl_done.
REQ-030 Flush during a store (0x3000, 0xDEADBEEF, len 11) -> ctl fields unchanged, mem_done still pulses.
REQ-031 With the guard enabled, continuous mem_req plus if_req -> fetch granted after exactly 4 data grants; with the guard disabled, fetch is never granted.
REQ-032 rst asserted in WAIT, then ctl_done -> no done pulse, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and codes for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } arb_src_t;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_B    = 2'b01;
  localparam logic [1:0] LEN_H    = 2'b10;
  localparam logic [1:0] LEN_W    = 2'b11;

  // A zero-length store never reaches the downstream port.
  function automatic logic is_null_store(input logic wr, input logic [1:0] len);
    return wr && (len == LEN_NONE);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests, with optional fetch starvation guard.
// MEM_ARB_STARVE_GUARD_EN enables the consecutive-data-grant counter.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     if_req,
  input  logic     mem_req,
  input  logic     grant_en,
  output arb_src_t win_src
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt >= CW'(STARVE_LIMIT));

  always_comb begin
    win_src = SRC_MEM;
    if (if_req && (!mem_req || starved)) win_src = SRC_IF;
  end

  // Only data grants made while a fetch is waiting count toward starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (win_src == SRC_IF || !if_req) starve_cnt <= '0;
      else if (!starved)                starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = clk ^ rst ^ grant_en ^ (STARVE_LIMIT != 0);

  always_comb begin
    win_src = SRC_MEM;
    if (if_req && !mem_req) win_src = SRC_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-source memory arbiter: instruction fetch and data port share one downstream channel.
// MEM_ARB_STARVE_GUARD_EN (see mem_arb_pick) lets a starved fetch win over data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_len,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        ctl_valid,
  output logic        ctl_wr,
  output logic [31:0] ctl_addr,
  output logic [31:0] ctl_wdata,
  output logic [1:0]  ctl_len,
  input  logic        ctl_ready,
  input  logic        ctl_done,
  input  logic [31:0] ctl_rdata,
  output logic        busy
);

  arb_state_t  state, state_nxt;
  logic        sel_vld, sel_vld_nxt;
  arb_src_t    sel_src;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_len;

  logic        if_req_m, mem_req_m, grant_en;
  arb_src_t    win_src;
  logic        if_done_nxt, mem_done_nxt, if_ld, mem_ld;

  // No arbitration while a done pulse is out, so the finishing source is not re-granted.
  assign if_req_m  = if_req && !flush && !if_done;
  assign mem_req_m = mem_req && !mem_done;
  assign grant_en  = (state == ST_IDLE) && !sel_vld && !if_done && !mem_done &&
                     (if_req_m || mem_req_m);

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req_m),
    .mem_req  (mem_req_m),
    .grant_en (grant_en),
    .win_src  (win_src)
  );

  always_comb begin
    state_nxt    = state;
    sel_vld_nxt  = 1'b0;
    if_done_nxt  = 1'b0;
    mem_done_nxt = 1'b0;
    if_ld        = 1'b0;
    mem_ld       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_vld) begin
          if (sel_src == SRC_IF && flush) state_nxt = ST_IDLE;
          else if (sel_src == SRC_MEM && is_null_store(sel_wr, sel_len)) mem_done_nxt = 1'b1;
          else state_nxt = ST_ISSUE;
        end else if (grant_en) begin
          sel_vld_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (sel_src == SRC_IF && flush) state_nxt = ST_IDLE;
        else if (ctl_ready)             state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctl_done) begin
          state_nxt = ST_IDLE;
          if (sel_src == SRC_MEM) begin
            mem_done_nxt = 1'b1;
            mem_ld       = 1'b1;
          end else if (!flush) begin
            if_done_nxt = 1'b1;
            if_ld       = 1'b1;
          end
        end else if (sel_src == SRC_IF && flush) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (ctl_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_vld   <= 1'b0;
      sel_src   <= SRC_IF;
      sel_wr    <= 1'b0;
      sel_addr  <= '0;
      sel_wdata <= '0;
      sel_len   <= LEN_NONE;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state    <= state_nxt;
      sel_vld  <= sel_vld_nxt;
      if_done  <= if_done_nxt;
      mem_done <= mem_done_nxt;
      if (if_ld)  if_rdata  <= ctl_rdata;
      if (mem_ld) mem_rdata <= ctl_rdata;
      if (grant_en) begin
        sel_src <= win_src;
        if (win_src == SRC_IF) begin
          sel_wr    <= 1'b0;
          sel_addr  <= if_addr;
          sel_wdata <= '0;
          sel_len   <= LEN_W;
        end else begin
          sel_wr    <= mem_wr;
          sel_addr  <= mem_addr;
          sel_wdata <= mem_wdata;
          sel_len   <= mem_len;
        end
      end
    end
  end

  assign ctl_valid = (state == ST_ISSUE);
  assign ctl_wr    = sel_wr;
  assign ctl_addr  = sel_addr;
  assign ctl_wdata = sel_wdata;
  assign ctl_len   = sel_len;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a downstream responder that attributes each access to its requester.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_wr, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_len;
  logic        ctl_valid, ctl_wr, ctl_ready, ctl_done, busy;
  logic [31:0] ctl_addr, ctl_wdata, ctl_rdata;
  logic [1:0]  ctl_len;

  int checks = 0;
  int failures = 0;

  bit          resp_en = 1'b0;
  int          own_q[$];
  logic [31:0] exp_if, exp_mem;
  bit          pend_if, pend_mem;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ctl_valid(ctl_valid), .ctl_wr(ctl_wr), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_len(ctl_len), .ctl_ready(ctl_ready), .ctl_done(ctl_done), .ctl_rdata(ctl_rdata),
    .busy(busy)
  );

  // Downstream model: attributes each access to the requester whose held fields it carries.
  initial begin
    int d, own;
    ctl_ready = 1'b0; ctl_done = 1'b0; ctl_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        ctl_ready = 1'b0; ctl_done = 1'b0;
        if (ctl_valid) begin
          d = $urandom_range(0, 2);
          repeat (d) @(negedge clk);
          own = -1;
          if (mem_req && ctl_wr === mem_wr && ctl_addr === mem_addr && ctl_len === mem_len &&
              (!mem_wr || ctl_wdata === mem_wdata))
            own = 1;
          else if (if_req && ctl_wr === 1'b0 && ctl_addr === if_addr && ctl_len === 2'b11)
            own = 0;
          checks++;
          if (own < 0) begin
            failures++;
            $display("FAIL ctl_owner: addr=%h wr=%b len=%b matches no pending request",
                     ctl_addr, ctl_wr, ctl_len);
          end
          own_q.push_back(own);
          ctl_ready = 1'b1;
          @(negedge clk);
          ctl_ready = 1'b0;
          d = $urandom_range(0, 3);
          repeat (d) @(negedge clk);
          ctl_rdata = $urandom;
          ctl_done  = 1'b1;
          if (own == 0) begin exp_if = ctl_rdata; pend_if = 1'b1; end
          else if (own == 1) begin exp_mem = ctl_rdata; pend_mem = 1'b1; end
        end
      end
    end
  end

  task automatic do_reset;
    resp_en = 1'b0;
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_len = 2'b00;
    ctl_ready = 1'b0; ctl_done = 1'b0; ctl_rdata = '0;
    exp_if = '0; exp_mem = '0; pend_if = 1'b0; pend_mem = 1'b0;
    own_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({if_done, mem_done, ctl_valid, busy, ctl_wr, ctl_len, ctl_addr, ctl_wdata,
         if_rdata, mem_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs, addr=%h rdata=%h/%h busy=%b",
               ctl_addr, if_rdata, mem_rdata, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ctl_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b ctl_valid=%b want 0/0", busy, ctl_valid);
    end
  endtask

  task automatic test_fetch;
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_1000;
    @(negedge clk);
    checks++;
    if (ctl_valid !== 1'b0) begin
      failures++; $display("FAIL fetch_lat1: ctl_valid=%b want 0", ctl_valid);
    end
    @(negedge clk);
    checks++;
    if (ctl_valid !== 1'b1 || ctl_len !== 2'b11 || ctl_addr !== 32'h1000 || ctl_wr !== 1'b0) begin
      failures++;
      $display("FAIL fetch_issue: valid=%b len=%b addr=%h wr=%b want 1/11/00001000/0",
               ctl_valid, ctl_len, ctl_addr, ctl_wr);
    end
    ctl_ready = 1'b1;
    @(negedge clk);
    ctl_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || ctl_valid !== 1'b0) begin
      failures++; $display("FAIL fetch_wait: busy=%b valid=%b want 1/0", busy, ctl_valid);
    end
    repeat (4) @(negedge clk);
    ctl_rdata = 32'h00C0_FFEE; ctl_done = 1'b1;
    checks++;
    if (if_done !== 1'b0) begin
      failures++; $display("FAIL fetch_early_done: if_done=%b want 0", if_done);
    end
    @(negedge clk);
    ctl_done = 1'b0;
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h00C0_FFEE || busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: if_done=%b rdata=%h busy=%b want 1/00c0ffee/0",
               if_done, if_rdata, busy);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0 || if_rdata !== 32'h00C0_FFEE || ctl_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_hold: if_done=%b rdata=%h valid=%b want 0/00c0ffee/0",
               if_done, if_rdata, ctl_valid);
    end
  endtask

  task automatic test_flush_fetch;
    do_reset();
    // flush while the fetch is waiting for data
    if_req = 1'b1; if_addr = 32'h0000_1100;
    repeat (2) @(negedge clk);
    ctl_ready = 1'b1;
    @(negedge clk);
    ctl_ready = 1'b0; flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy: busy=%b want 1", busy); end
    @(negedge clk);
    ctl_rdata = 32'h5555_AAAA; ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || if_done !== 1'b0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL drop_absorb: busy=%b if_done=%b rdata=%h want 0/0/00000000",
               busy, if_done, if_rdata);
    end
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0 || ctl_valid !== 1'b0) begin
      failures++; $display("FAIL drop_after: if_done=%b valid=%b want 0/0", if_done, ctl_valid);
    end
    // flush in IDLE masks the fetch for that cycle; flush in ISSUE drops it
    if_req = 1'b1; if_addr = 32'h0000_1200; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl_valid !== 1'b0) begin
      failures++; $display("FAIL flush_mask: ctl_valid=%b want 0", ctl_valid);
    end
    @(negedge clk);
    checks++;
    if (ctl_valid !== 1'b1) begin
      failures++; $display("FAIL flush_mask_late: ctl_valid=%b want 1", ctl_valid);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; if_req = 1'b0;
    checks++;
    if (ctl_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_issue: valid=%b busy=%b want 0/0", ctl_valid, busy);
    end
    // flush while the fetch is selected but not yet issued
    if_req = 1'b1; if_addr = 32'h0000_1300;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ctl_valid !== 1'b0 || busy !== 1'b0 || if_done !== 1'b0) begin
        failures++;
        $display("FAIL flush_sel: valid=%b busy=%b if_done=%b want 0/0/0",
                 ctl_valid, busy, if_done);
      end
    end
  endtask

  task automatic test_flush_store;
    do_reset();
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_3000;
    mem_wdata = 32'hDEAD_BEEF; mem_len = 2'b11; flush = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl_valid !== 1'b1 || ctl_wr !== 1'b1 || ctl_addr !== 32'h3000 ||
        ctl_wdata !== 32'hDEAD_BEEF || ctl_len !== 2'b11) begin
      failures++;
      $display("FAIL store_issue: valid=%b wr=%b addr=%h wdata=%h len=%b",
               ctl_valid, ctl_wr, ctl_addr, ctl_wdata, ctl_len);
    end
    @(negedge clk);
    checks++;
    if (ctl_valid !== 1'b1 || ctl_addr !== 32'h3000 || ctl_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_stable: valid=%b addr=%h wdata=%h want 1/00003000/deadbeef",
               ctl_valid, ctl_addr, ctl_wdata);
    end
    ctl_ready = 1'b1;
    @(negedge clk);
    ctl_ready = 1'b0;
    @(negedge clk);
    ctl_rdata = 32'h0000_1234; ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0; flush = 1'b0;
    checks++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'h1234) begin
      failures++;
      $display("FAIL store_done: mem_done=%b rdata=%h want 1/00001234", mem_done, mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b0) begin
      failures++; $display("FAIL store_pulse: mem_done=%b want 0", mem_done);
    end
  endtask

  task automatic test_zero_len;
    logic [31:0] prev;
    prev = mem_rdata;
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_3100; mem_wdata = 32'h1; mem_len = 2'b00;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b0) begin
      failures++; $display("FAIL zlen_early: mem_done=%b want 0", mem_done);
    end
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || ctl_valid !== 1'b0 || mem_rdata !== prev) begin
      failures++;
      $display("FAIL zlen_done: mem_done=%b valid=%b rdata=%h want 1/0/%h",
               mem_done, ctl_valid, mem_rdata, prev);
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b0 || busy !== 1'b0 || ctl_valid !== 1'b0) begin
      failures++;
      $display("FAIL zlen_after: done=%b busy=%b valid=%b want 0/0/0", mem_done, busy, ctl_valid);
    end
  endtask

  task automatic test_priority;
    int n_if, n_mem, first;
    do_reset();
    resp_en = 1'b1;
    n_if = 0; n_mem = 0; first = -1;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_2000; mem_len = 2'b10;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    repeat (60) begin
      @(negedge clk);
      if (mem_done) begin n_mem++; mem_req = 1'b0; if (first < 0) first = 1; end
      if (if_done) begin
        n_if++; if_req = 1'b0; if (first < 0) first = 0;
        checks++;
        if (if_rdata !== exp_if) begin
          failures++; $display("FAIL prio_if_rdata: got %h want %h", if_rdata, exp_if);
        end
      end
    end
    checks++;
    if (n_mem != 1 || n_if != 1 || first != 1) begin
      failures++;
      $display("FAIL prio_done: mem_pulses=%0d if_pulses=%0d first=%0d want 1/1/1",
               n_mem, n_if, first);
    end
    checks++;
    if (own_q.size() != 2 || own_q[0] != 1 || own_q[1] != 0) begin
      failures++; $display("FAIL prio_order: accesses=%0d want data then fetch", own_q.size());
    end
  endtask

  task automatic test_starve;
    int t, lead;
    bit stop, got_if;
    do_reset();
    resp_en = 1'b1;
    stop = 1'b0;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h2000_0000; mem_len = 2'b11;
    if_req = 1'b1; if_addr = 32'h1000_0040;
    t = 0;
    while (t < 800 && !(stop && !mem_req && !if_req)) begin
      @(negedge clk);
      t++;
      if (mem_done) begin
        if (stop) mem_req = 1'b0;
        else mem_addr = mem_addr + 32'd4;
      end
      if (if_done) if_req = 1'b0;
      if (own_q.size() >= 6) stop = 1'b1;
    end
    checks++;
    if (mem_req || if_req) begin
      failures++; $display("FAIL starve_timeout: mem_req=%b if_req=%b still pending", mem_req, if_req);
      mem_req = 1'b0; if_req = 1'b0;
    end
    lead = 0; got_if = 1'b0;
    for (int i = 0; i < 6 && i < own_q.size(); i++) begin
      if (own_q[i] == 0) got_if = 1'b1;
      else if (!got_if) lead++;
    end
    checks++;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (!got_if || lead != LIMIT) begin
      failures++; $display("FAIL starve_guard: data grants before fetch=%0d want %0d", lead, LIMIT);
    end
`else
    if (got_if) begin
      failures++; $display("FAIL strict_prio: fetch granted after %0d data grants, want never", lead);
    end
`endif
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random;
    do_reset();
    resp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          int t;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          mem_wr    = 1'($urandom_range(0, 1));
          mem_addr  = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
          mem_wdata = $urandom;
          mem_len   = mem_wr ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
          mem_req   = 1'b1;
          t = 0;
          do begin @(negedge clk); t++; end while (!mem_done && t < 300);
          checks++;
          if (!mem_done) begin
            failures++; $display("FAIL rnd_mem_timeout: no mem_done after %0d cycles", t);
          end else if (mem_wr && mem_len == 2'b00) begin
            if (pend_mem || mem_rdata !== exp_mem) begin
              failures++;
              $display("FAIL rnd_null_store: downstream=%b rdata=%h want 0/%h", pend_mem, mem_rdata, exp_mem);
            end
          end else if (!pend_mem || mem_rdata !== exp_mem) begin
            failures++;
            $display("FAIL rnd_mem_rdata: accessed=%b rdata=%h want 1/%h", pend_mem, mem_rdata, exp_mem);
          end
          pend_mem = 1'b0; mem_req = 1'b0;
          @(negedge clk);
          checks++;
          if (mem_done !== 1'b0) begin
            failures++; $display("FAIL rnd_mem_pulse: mem_done=%b want 0", mem_done);
          end
        end
      end
      begin
        for (int i = 0; i < 14; i++) begin
          int t;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if_addr = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
          if_req  = 1'b1;
          t = 0;
          do begin @(negedge clk); t++; end while (!if_done && t < 300);
          checks++;
          if (!if_done) begin
            failures++; $display("FAIL rnd_if_timeout: no if_done after %0d cycles", t);
          end else if (!pend_if || if_rdata !== exp_if) begin
            failures++;
            $display("FAIL rnd_if_rdata: accessed=%b rdata=%h want 1/%h", pend_if, if_rdata, exp_if);
          end
          pend_if = 1'b0; if_req = 1'b0;
          @(negedge clk);
          checks++;
          if (if_done !== 1'b0) begin
            failures++; $display("FAIL rnd_if_pulse: if_done=%b want 0", if_done);
          end
        end
      end
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_1400;
    repeat (2) @(negedge clk);
    ctl_ready = 1'b1;
    @(negedge clk);
    ctl_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0;
    checks++;
    if ({if_done, mem_done, ctl_valid, busy, ctl_wr, ctl_len, ctl_addr, ctl_wdata,
         if_rdata, mem_rdata} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: busy=%b valid=%b addr=%h rdata=%h", busy, ctl_valid, ctl_addr, if_rdata);
    end
    @(negedge clk);
    ctl_rdata = 32'hFFFF_FFFF; ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    repeat (2) begin
      checks++;
      if ({if_done, mem_done, ctl_valid, busy, if_rdata, mem_rdata} !== '0) begin
        failures++;
        $display("FAIL rst_late_done: if_done=%b mem_done=%b busy=%b rdata=%h want all 0",
                 if_done, mem_done, busy, if_rdata);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_flush_fetch();
    test_flush_store();
    test_zero_len();
    test_priority();
    test_starve();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
